// File: rtl/funct_generator_pkg.sv
// Purpose     : shared widths and FSM state encoding for the funct_generator waveform source.
// Latency     : n/a (declarations only).
// Backpressure: n/a.
package funct_generator_pkg;

   localparam int DATA_WIDTH_DEF  = 5;
   localparam int PHASE_WIDTH_DEF = 8;
   localparam int DIV_WIDTH_DEF   = 8;

   // Plain vector encoding keeps the state register readable in older tools.
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t LOAD = 2'd1;
   localparam state_t RUN  = 2'd2;

endpackage

// File: rtl/funct_generator_phase_acc.sv
// Purpose     : one phase accumulator; exposes the top bits of the NEXT phase for waveform mapping.
// Latency     : phase register updates on the edge where adv=1; phase_top is combinational.
// Backpressure: none internally; the caller withholds adv while stalled.
// Ports: clk, clrh (sync reset), adv (advance enable), step (increment),
//        phase_top (top TOP_WIDTH bits of phase+step).
module funct_generator_phase_acc
   import funct_generator_pkg::*;
#(
   parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
   parameter int TOP_WIDTH   = DATA_WIDTH_DEF + 1
) (
   input  logic                   clk,
   input  logic                   clrh,
   input  logic                   adv,
   input  logic [PHASE_WIDTH-1:0] step,
   output logic [TOP_WIDTH-1:0]   phase_top
);

   logic [PHASE_WIDTH-1:0] phase;
   logic [PHASE_WIDTH-1:0] phase_nxt;

   // Wraps modulo 2^PHASE_WIDTH by construction.
   assign phase_nxt = phase + step;
   assign phase_top = phase_nxt[PHASE_WIDTH-1 -: TOP_WIDTH];

   always_ff @(posedge clk) begin
      if (clrh) begin
         phase <= '0;
      end else if (adv) begin
         phase <= phase_nxt;
      end
   end

endmodule

// File: rtl/funct_generator_wavegen.sv
// Purpose     : three-channel sawtooth/triangle/square source with prescaled sample rate.
// Latency     : sample registered one edge after its prescaler tick; valid_o rises on that edge.
// Backpressure: valid/ready; while stalled the sample is held, phases freeze, ticks are dropped (overrun_o).
// Ports: clk, clrh (sync reset), enh (run enable), div_i (prescaler terminal),
//        step_a_i/step_b_i/step_c_i (phase increments), ready_i,
//        data_a_o/data_b_o/data_c_o (samples), valid_o, overrun_o (sticky dropped-tick flag).
module funct_generator_wavegen
   import funct_generator_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
   parameter int DIV_WIDTH   = DIV_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   clrh,
   input  logic                   enh,
   input  logic [DIV_WIDTH-1:0]   div_i,
   input  logic [PHASE_WIDTH-1:0] step_a_i,
   input  logic [PHASE_WIDTH-1:0] step_b_i,
   input  logic [PHASE_WIDTH-1:0] step_c_i,
   input  logic                   ready_i,
   output logic [DATA_WIDTH-1:0]  data_a_o,
   output logic [DATA_WIDTH-1:0]  data_b_o,
   output logic [DATA_WIDTH-1:0]  data_c_o,
   output logic                   valid_o,
   output logic                   overrun_o
);

   state_t                 state;
   logic [DIV_WIDTH-1:0]   div_q;
   logic [DIV_WIDTH-1:0]   div_cnt;
   logic [PHASE_WIDTH-1:0] step_a_q;
   logic [PHASE_WIDTH-1:0] step_b_q;
   logic [PHASE_WIDTH-1:0] step_c_q;

   logic                   run;
   logic                   tick;
   logic                   adv;

   logic [DATA_WIDTH-1:0]  top_a;
   logic [DATA_WIDTH:0]    top_b;
   logic                   top_c;
   logic [DATA_WIDTH-1:0]  saw;
   logic [DATA_WIDTH-1:0]  tri_w;
   logic [DATA_WIDTH-1:0]  sqr;

   // enh low in RUN takes the exit path this edge, so nothing advances on it.
   assign run  = (state == RUN) && enh;
   assign tick = run && (div_cnt == div_q);
   // A tick only turns into a sample when the output slot is free or being emptied now.
   assign adv  = tick && (!valid_o || ready_i);

   funct_generator_phase_acc #(.PHASE_WIDTH(PHASE_WIDTH), .TOP_WIDTH(DATA_WIDTH)) u_acc_a (
      .clk(clk), .clrh(clrh), .adv(adv), .step(step_a_q), .phase_top(top_a)
   );
   funct_generator_phase_acc #(.PHASE_WIDTH(PHASE_WIDTH), .TOP_WIDTH(DATA_WIDTH+1)) u_acc_b (
      .clk(clk), .clrh(clrh), .adv(adv), .step(step_b_q), .phase_top(top_b)
   );
   funct_generator_phase_acc #(.PHASE_WIDTH(PHASE_WIDTH), .TOP_WIDTH(1)) u_acc_c (
      .clk(clk), .clrh(clrh), .adv(adv), .step(step_c_q), .phase_top(top_c)
   );

   // Waveforms are mapped from the updated phase so the registered sample matches the new phase.
   assign saw   = top_a;
   assign tri_w = top_b[DATA_WIDTH] ? ~top_b[DATA_WIDTH-1:0] : top_b[DATA_WIDTH-1:0];
   assign sqr   = {DATA_WIDTH{top_c}};

   always_ff @(posedge clk) begin
      if (clrh) begin
         state     <= IDLE;
         div_q     <= '0;
         div_cnt   <= '0;
         step_a_q  <= '0;
         step_b_q  <= '0;
         step_c_q  <= '0;
         data_a_o  <= '0;
         data_b_o  <= '0;
         data_c_o  <= '0;
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enh) state <= LOAD;
            end
            LOAD: begin
               div_q    <= div_i;
               step_a_q <= step_a_i;
               step_b_q <= step_b_i;
               step_c_q <= step_c_i;
               div_cnt  <= '0;
               state    <= RUN;
            end
            RUN: begin
               if (!enh) begin
                  state   <= IDLE;
                  valid_o <= 1'b0;
               end else begin
                  div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
                  if (adv) begin
                     data_a_o <= saw;
                     data_b_o <= tri_w;
                     data_c_o <= sqr;
                     valid_o  <= 1'b1;
                  end else if (valid_o && ready_i) begin
                     valid_o  <= 1'b0;
                  end
                  if (tick && !adv) overrun_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_funct_generator_wavegen.sv
// Purpose     : self-checking bench for funct_generator_wavegen (cycle model + directed literals).
// Latency     : n/a.
// Backpressure: ready_i driven directly by the stimulus.
module tb_funct_generator_wavegen;

   localparam int DW = 5;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          clrh, enh, ready_i;
   logic [7:0]    div_i, step_a_i, step_b_i, step_c_i;
   logic [DW-1:0] data_a_o, data_b_o, data_c_o;
   logic          valid_o, overrun_o;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   funct_generator_wavegen dut (
      .clk(clk), .clrh(clrh), .enh(enh), .div_i(div_i),
      .step_a_i(step_a_i), .step_b_i(step_b_i), .step_c_i(step_c_i),
      .ready_i(ready_i), .data_a_o(data_a_o), .data_b_o(data_b_o),
      .data_c_o(data_c_o), .valid_o(valid_o), .overrun_o(overrun_o)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Waveform rules as plain arithmetic on the integer phase (0..255).
   function automatic int f_saw(input int p); return (p >> (PW - DW)) % 32; endfunction
   function automatic int f_tri(input int p);
      int q;
      q = p >> (PW - DW - 1);
      return (q < 32) ? q : 63 - q;
   endfunction
   function automatic int f_sqr(input int p); return (p >= 128) ? 31 : 0; endfunction

   // Behavioural model: 0=idle, 1=load, 2=run.
   int m_st = 0, m_cnt = 0, m_div = 0;
   int m_sa = 0, m_sb = 0, m_sc = 0;
   int m_pa = 0, m_pb = 0, m_pc = 0;
   int m_da = 0, m_db = 0, m_dc = 0;
   int m_v = 0, m_ov = 0;

   always @(posedge clk) begin : model
      bit t;
      if (clrh) begin
         m_st = 0; m_cnt = 0; m_div = 0; m_sa = 0; m_sb = 0; m_sc = 0;
         m_pa = 0; m_pb = 0; m_pc = 0; m_da = 0; m_db = 0; m_dc = 0;
         m_v = 0; m_ov = 0;
      end else if (m_st == 0) begin
         if (enh) m_st = 1;
      end else if (m_st == 1) begin
         m_div = int'(div_i); m_sa = int'(step_a_i); m_sb = int'(step_b_i); m_sc = int'(step_c_i);
         m_cnt = 0; m_st = 2;
      end else if (!enh) begin
         m_st = 0; m_v = 0;
      end else begin
         t = (m_cnt == m_div);
         m_cnt = t ? 0 : m_cnt + 1;
         if (t && (m_v == 0 || ready_i)) begin
            m_pa = (m_pa + m_sa) % 256;
            m_pb = (m_pb + m_sb) % 256;
            m_pc = (m_pc + m_sc) % 256;
            m_da = f_saw(m_pa); m_db = f_tri(m_pb); m_dc = f_sqr(m_pc);
            m_v = 1;
         end else begin
            if (t) m_ov = 1;
            if (m_v == 1 && ready_i) m_v = 0;
         end
      end
   end

   always @(negedge clk) begin : compare
      if (chk_en) begin
         chk("mdl_valid",   int'(valid_o),   m_v);
         chk("mdl_data_a",  int'(data_a_o),  m_da);
         chk("mdl_data_b",  int'(data_b_o),  m_db);
         chk("mdl_data_c",  int'(data_c_o),  m_dc);
         chk("mdl_overrun", int'(overrun_o), m_ov);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clrh = 1'b1; enh = 1'b0;
      cyc(1);
      clrh = 1'b0;
   endtask

   initial begin
      int nval;
      clrh = 1'b1; enh = 1'b0; ready_i = 1'b0;
      div_i = 8'd0; step_a_i = 8'd0; step_b_i = 8'd0; step_c_i = 8'd0;
      cyc(2);
      chk_en = 1'b1;
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_data_a", int'(data_a_o), 0);
      chk("rst_overrun", int'(overrun_o), 0);

      // Sawtooth: first sample three edges after enh rises (IDLE->LOAD->RUN->tick).
      clrh = 1'b0; div_i = 8'd0; step_a_i = 8'd8; ready_i = 1'b1; enh = 1'b1;
      cyc(3);
      chk("saw_first", int'(data_a_o), 1);
      chk("saw_first_valid", int'(valid_o), 1);
      cyc(30);
      chk("saw_top", int'(data_a_o), 31);
      cyc(1);
      chk("saw_wrap", int'(data_a_o), 0);
      chk("saw_wrap_valid", int'(valid_o), 1);

      // Reset mid-RUN with a valid sample pending.
      clrh = 1'b1; enh = 1'b0;
      cyc(2);
      chk("midrst_valid", int'(valid_o), 0);
      chk("midrst_data_a", int'(data_a_o), 0);
      clrh = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("postrst_novalid", int'(valid_o), 0);
      end

      // Triangle/square: step 4 walks the 6-bit phase top one count per sample.
      step_a_i = 8'd8; step_b_i = 8'd4; step_c_i = 8'd4; div_i = 8'd0; enh = 1'b1;
      cyc(3);
      chk("tri_first", int'(data_b_o), 1);
      chk("sq_first", int'(data_c_o), 0);
      cyc(30);
      chk("tri_peak", int'(data_b_o), 31);
      chk("sq_low_end", int'(data_c_o), 0);
      cyc(1);
      chk("tri_peak2", int'(data_b_o), 31);
      chk("sq_high", int'(data_c_o), 31);
      cyc(31);
      chk("tri_floor", int'(data_b_o), 0);
      chk("sq_high_end", int'(data_c_o), 31);

      // Prescale: div 3 -> first sample 6 edges after enh, then every 4.
      do_reset();
      div_i = 8'd3; step_a_i = 8'd8; step_b_i = 8'd0; step_c_i = 8'd0; ready_i = 1'b1; enh = 1'b1;
      nval = 0;
      for (int i = 0; i < 21; i++) begin
         cyc(1);
         if (valid_o) nval++;
      end
      chk("presc_nvalid", nval, 4);
      chk("presc_data_a", int'(data_a_o), 4);

      // Stall: div 1, ready low for 6 cycles starting with sample 2 pending.
      do_reset();
      div_i = 8'd1; step_a_i = 8'd8; ready_i = 1'b1; enh = 1'b1;
      cyc(6);
      chk("stall_pre", int'(data_a_o), 2);
      ready_i = 1'b0;
      cyc(6);
      chk("stall_hold", int'(data_a_o), 2);
      chk("stall_valid", int'(valid_o), 1);
      chk("stall_overrun", int'(overrun_o), 1);
      ready_i = 1'b1;
      cyc(2);
      chk("stall_resume", int'(data_a_o), 3);

      // Config: step change in RUN is ignored until enh is cycled.
      step_a_i = 8'd16;
      cyc(4);
      chk("cfg_ignored", int'(data_a_o), 5);
      enh = 1'b0;
      cyc(1);
      chk("cfg_idle_valid", int'(valid_o), 0);
      chk("cfg_idle_hold", int'(data_a_o), 5);
      enh = 1'b1;
      cyc(4);
      chk("cfg_new_step", int'(data_a_o), 7);
      chk("overrun_sticky", int'(overrun_o), 1);
      cyc(8);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
